// File: rtl/uart_rx_tx_if.sv
// Byte-stream handshake bundle between the UART and on-chip logic.
// master = byte producer/consumer logic, slave = the UART block.
interface uart_rx_tx_if;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;

  modport master (
    output tx_data, tx_data_valid, rx_data_ready,
    input  tx_data_ready, rx_data, rx_data_valid
  );

  modport slave (
    input  tx_data, tx_data_valid, rx_data_ready,
    output tx_data_ready, rx_data, rx_data_valid
  );
endinterface

// File: rtl/uart_rx_tx.sv
// 8N1 UART transmitter and receiver with valid/ready byte handshakes.
// Define UART_PARITY_EN to add an even-parity bit after data bit 7.
module uart_rx_tx #(
  parameter int CLK_FRE   = 100,
  parameter int BAUD_RATE = 115200
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_tx_if.slave   bus,
  output logic          tx_pin,
  input  logic          rx_pin
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CNT_W = $clog2(CYCLE + 1);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(CYCLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLE / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP, RX_DONE
  } rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t        tx_state_reg, tx_state_next;
  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]       tx_bit_reg, tx_bit_next;
  logic [7:0]       tx_shift_reg, tx_shift_next;
  logic             tx_ready;
  logic             tx_bit_end;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_ready      = 1'b0;
    tx_pin        = 1'b1;
    tx_bit_end    = (tx_cnt_reg == LAST);
    if (tx_state_reg != TX_IDLE)
      tx_cnt_next = tx_bit_end ? '0 : tx_cnt_reg + 1'b1;
    case (tx_state_reg)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (bus.tx_data_valid) begin
          tx_shift_next = bus.tx_data;
          tx_cnt_next   = '0;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        tx_pin = 1'b0;
        if (tx_bit_end) begin
          tx_bit_next   = '0;
          tx_state_next = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_pin = tx_shift_reg[tx_bit_reg];
        if (tx_bit_end) begin
          tx_bit_next = tx_bit_reg + 1'b1;
          if (tx_bit_reg == 3'd7)
`ifdef UART_PARITY_EN
            tx_state_next = TX_PARITY;
`else
            tx_state_next = TX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        tx_pin = ^tx_shift_reg;
        if (tx_bit_end) tx_state_next = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (tx_bit_end) tx_state_next = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  assign bus.tx_data_ready = tx_ready;

  // ---------------- receiver ----------------
  // Synchronizer flops reset to the idle level so reset never fakes a start edge.
  logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx_pin;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  rx_state_t        rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]       rx_bit_reg, rx_bit_next;
  logic [7:0]       rx_shift_reg, rx_shift_next;
  logic [7:0]       rx_data_reg, rx_data_next;
  logic             rx_valid_reg, rx_valid_next;
  logic             rx_bit_end;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_bit_end    = (rx_cnt_reg == LAST);
    // A completion in the same cycle as a consume overrides the clear below.
    rx_data_next  = rx_data_reg;
    rx_valid_next = bus.rx_data_ready ? 1'b0 : rx_valid_reg;
    if (rx_state_reg != RX_IDLE && rx_state_reg != RX_DONE)
      rx_cnt_next = rx_bit_end ? '0 : rx_cnt_reg + 1'b1;
    case (rx_state_reg)
      RX_IDLE: begin
        rx_cnt_next = '0;
        if (rx_prev_reg && !rx_sync_reg) rx_state_next = RX_START;
      end
      RX_START: begin
        // Half-period recheck; all later samples land one full period apart, mid-bit.
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next = '0;
          rx_bit_next = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          rx_bit_next   = rx_bit_reg + 1'b1;
          if (rx_bit_reg == 3'd7)
`ifdef UART_PARITY_EN
            rx_state_next = RX_PARITY;
`else
            rx_state_next = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_bit_end)
          rx_state_next = (rx_sync_reg == ^rx_shift_reg) ? RX_STOP : RX_IDLE;
      end
`endif
      RX_STOP: begin
        if (rx_bit_end) rx_state_next = rx_sync_reg ? RX_DONE : RX_IDLE;
      end
      RX_DONE: begin
        rx_data_next  = rx_shift_reg;
        rx_valid_next = 1'b1;
        rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  assign bus.rx_data       = rx_data_reg;
  assign bus.rx_data_valid = rx_valid_reg;

endmodule

// File: tb/tb_uart_rx_tx.sv
// Directed bench for uart_rx_tx: loopback, hold, overrun, glitch/framing,
// mid-frame reset and (with UART_PARITY_EN) parity.
module tb_uart_rx_tx;

  localparam int C = 100 * 1000000 / 115200;  // 868
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_en = 1'b1;
  logic drv_pin = 1'b1;
  logic tx_pin;
  logic rx_pin;
  int   checks = 0;
  int   errors = 0;
  int   valid_rises = 0;
  logic valid_d = 1'b0;

  uart_rx_tx_if bus_if ();

  assign rx_pin = loop_en ? tx_pin : drv_pin;

  uart_rx_tx #(.CLK_FRE(100), .BAUD_RATE(115200)) dut (
    .clk   (clk),
    .rst_n (rst),
    .bus   (bus_if),
    .tx_pin(tx_pin),
    .rx_pin(rx_pin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    valid_d <= bus_if.rx_data_valid;
    if (bus_if.rx_data_valid && !valid_d) valid_rises <= valid_rises + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one byte through the TX handshake and watch the whole frame.
  task automatic tx_send(input logic [7:0] b, input bit chk_rx, input bit chk_lat);
    logic [NB-1:0] frame;
    logic [NB-1:0] exp_frame;
    int ready_cyc;
    int valid_n;
    int mid_stop;
    @(negedge clk);
    bus_if.tx_data = b;
    bus_if.tx_data_valid = 1'b1;
    chk("tx_ready_before_accept", bus_if.tx_data_ready, 1);
    @(posedge clk);
    #1;
    bus_if.tx_data_valid = 1'b0;
    bus_if.tx_data = 8'h00;
    @(negedge clk);
    chk("tx_ready_cycle1", bus_if.tx_data_ready, 0);
    chk("tx_start_cycle1", tx_pin, 0);
    frame = '0;
    ready_cyc = 0;
    valid_n = 0;
    for (int n = 1; n <= NB * C + 2; n++) begin
      @(posedge clk);
      @(negedge clk);
      if ((n % C) == C / 2 && (n / C) < NB) frame[n / C] = tx_pin;
      if (bus_if.tx_data_ready && ready_cyc == 0) ready_cyc = n + 1;
      if (bus_if.rx_data_valid && valid_n == 0) valid_n = n;
    end
`ifdef UART_PARITY_EN
    exp_frame = {1'b1, ^b, b, 1'b0};
`else
    exp_frame = {1'b1, b, 1'b0};
`endif
    chk("tx_frame_bits", 32'(frame), 32'(exp_frame));
    chk("tx_ready_return_cycle", ready_cyc, NB * C + 1);
    if (chk_rx) begin
      chk("rx_data_loopback", bus_if.rx_data, 32'(b));
      chk("rx_valid_loopback", bus_if.rx_data_valid, 1);
    end
    if (chk_lat) begin
      mid_stop = (NB - 1) * C + C / 2;
      chk("rx_valid_latency_window", 32'(valid_n >= mid_stop && valid_n <= mid_stop + 5), 1);
    end
    $display("tx byte %02h frame %b ready_cycle %0d rx %02h valid %0d",
             b, frame, ready_cyc, bus_if.rx_data, bus_if.rx_data_valid);
  endtask

  task automatic consume();
    @(negedge clk);
    bus_if.rx_data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rx_valid_cleared", bus_if.rx_data_valid, 0);
    bus_if.rx_data_ready = 1'b0;
    $display("rx consume");
  endtask

  // Bit-bang a frame on rx_pin (LSB first), C clocks per bit, then one idle period.
  task automatic drive_bits(input logic [15:0] bits, input int nb);
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      drv_pin = bits[k];
      repeat (C - 1) @(negedge clk);
    end
    @(negedge clk);
    drv_pin = 1'b1;
    repeat (C) @(negedge clk);
    $display("rx driven frame %b (%0d bits)", bits, nb);
  endtask

  initial begin
    int rises0;
    bus_if.tx_data = 8'h00;
    bus_if.tx_data_valid = 1'b0;
    bus_if.rx_data_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx_pin", tx_pin, 1);
    chk("reset_tx_ready", bus_if.tx_data_ready, 1);
    chk("reset_rx_data", bus_if.rx_data, 0);
    chk("reset_rx_valid", bus_if.rx_data_valid, 0);
    rst = 1'b0;
    while ($time < 90) @(negedge clk);

    // Loopback 0xA5, then consume
    tx_send(8'hA5, 1'b1, 1'b1);
    consume();

    // Hold: valid stays up until ready
    tx_send(8'h3C, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    chk("hold_rx_valid", bus_if.rx_data_valid, 1);
    chk("hold_rx_data", bus_if.rx_data, 8'h3C);
    consume();

    // Overrun: second byte replaces first
    tx_send(8'h11, 1'b1, 1'b0);
    tx_send(8'h22, 1'b1, 1'b0);
    chk("overrun_rx_data", bus_if.rx_data, 8'h22);
    chk("overrun_rx_valid", bus_if.rx_data_valid, 1);
    consume();

    // Glitch: 100-clock low pulse is rejected by the half-period recheck
    loop_en = 1'b0;
    rises0 = valid_rises;
    @(negedge clk);
    drv_pin = 1'b0;
    repeat (100) @(negedge clk);
    drv_pin = 1'b1;
    repeat (2 * C) @(negedge clk);
    chk("glitch_no_valid", valid_rises - rises0, 0);
    chk("glitch_rx_data_kept", bus_if.rx_data, 8'h22);
    $display("rx glitch pulse 100 clocks");

    // Framing error: stop bit 0
`ifdef UART_PARITY_EN
    drive_bits({5'b0, 1'b0, ^8'h81, 8'h81, 1'b0}, 11);
`else
    drive_bits({6'b0, 1'b0, 8'h81, 1'b0}, 10);
`endif
    chk("framing_no_valid", valid_rises - rises0, 0);
    chk("framing_rx_data_kept", bus_if.rx_data, 8'h22);
`ifdef UART_PARITY_EN
    drive_bits({5'b0, 1'b1, ^8'h96, 8'h96, 1'b0}, 11);
`else
    drive_bits({6'b0, 1'b1, 8'h96, 1'b0}, 10);
`endif
    chk("after_framing_rx_data", bus_if.rx_data, 8'h96);
    chk("after_framing_rx_valid", bus_if.rx_data_valid, 1);
    consume();

    // Reset during TX bit 3 of 0x00
    loop_en = 1'b1;
    @(negedge clk);
    bus_if.tx_data = 8'h00;
    bus_if.tx_data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.tx_data_valid = 1'b0;
    repeat (4 * C + C / 2) @(posedge clk);
    @(negedge clk);
    chk("midframe_bit3_low", tx_pin, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_tx_pin", tx_pin, 1);
    chk("midreset_tx_ready", bus_if.tx_data_ready, 1);
    chk("midreset_rx_data", bus_if.rx_data, 0);
    rst = 1'b0;
    $display("reset during tx bit 3");
    tx_send(8'h5A, 1'b1, 1'b1);
    consume();

`ifdef UART_PARITY_EN
    // Parity: 0x07 has three ones, so the even-parity bit is 1
    tx_send(8'h07, 1'b1, 1'b0);
    consume();
    loop_en = 1'b0;
    rises0 = valid_rises;
    drive_bits({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    chk("parity_flip_no_valid", valid_rises - rises0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_tx.md
# uart_rx_tx

8N1 UART block: a transmitter that serializes bytes offered on a valid/ready handshake onto `tx_pin`, and an independent receiver that deserializes `rx_pin` into bytes presented on a valid/ready handshake. It sits between the on-chip byte-stream logic and the board serial pins. In loopback (`rx_pin` tied to `tx_pin`) every transmitted byte is received unchanged.

## Interface
- `CLK_FRE`, 100: clock frequency in MHz (integer).
- `BAUD_RATE`, 115200: bit rate in bit/s. Bit period is `CYCLE = CLK_FRE*1000000/BAUD_RATE` clocks, truncated; 868 at the defaults.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-high reset: a 1 sampled on a rising `clk` edge resets the block. The name is kept for codebase consistency; the polarity is high.
- `tx_data`  in  8  byte to send; sampled only on acceptance.
- `tx_data_valid`  in  1  transmit request.
- `tx_data_ready`  out  1  transmitter idle; a byte is accepted when valid and ready are both 1.
- `tx_pin`  out  1  serial output; idles at 1.
- `rx_pin`  in  1  serial input; asynchronous to `clk`.
- `rx_data`  out  8  last received byte.
- `rx_data_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_data_ready`  in  1  consumer accepts `rx_data` on valid and ready.

## Operation
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts `CYCLE` clocks.
- TX states: IDLE, START, DATA, STOP.
  - In IDLE, `tx_data_ready` is 1.
  - On acceptance, latch `tx_data` and go to START.
  - START drives 0 for `CYCLE` clocks.
  - DATA drives bit 0 through bit 7, `CYCLE` clocks each.
  - STOP drives 1 for `CYCLE` clocks, then returns to IDLE.
  - `tx_data_valid` is ignored outside IDLE.
- RX states: IDLE, START, DATA, STOP, DONE.
  - `rx_pin` passes through a 2-flop synchronizer.
  - In IDLE, a synchronized 1→0 transition enters START.
  - START samples the line at `CYCLE/2`. If it reads 1, the event is a glitch: return to IDLE.
  - DATA samples each bit at its midpoint, shifting LSB first.
  - STOP samples at mid-stop. If it reads 1, load `rx_data` and set `rx_data_valid`. If it reads 0 (framing error), discard the byte and leave valid unchanged.
  - The receiver then returns to IDLE without waiting for the end of the stop bit, so back-to-back frames are received.
- RX handshake:
  - `rx_data_valid` is held until a cycle with `rx_data_ready`=1, then cleared.
  - If a new byte completes while valid is still 1, it overwrites `rx_data` and valid stays 1 (overrun; the older byte is lost).
  - If the clear and a new completion happen in the same cycle, the completion wins: valid=1 with the new data.
- Reset values: `tx_pin`=1, `tx_data_ready`=1, `rx_data`=0x00, `rx_data_valid`=0. Both FSMs return to IDLE and all counters clear. Reset mid-frame aborts the frame immediately: the line returns to 1 and a partial RX byte is discarded.

## Timing
- TX: the acceptance edge is cycle 0.
  - `tx_data_ready` is 0 from cycle 1.
  - `tx_pin` is 0 from cycle 1 through `CYCLE`.
  - Data bit k occupies cycles `(1+k)*CYCLE+1` through `(2+k)*CYCLE`.
  - The stop bit ends at `10*CYCLE`.
  - `tx_data_ready` returns to 1 at cycle `10*CYCLE+1`, so the earliest next acceptance is that cycle.
- RX: the synchronized falling edge lags the pin by 2 clocks.
  - `rx_data_valid` rises within 2 clocks after the mid-stop sample, about `9.5*CYCLE+3` clocks after the start-bit edge on the pin.
- Tolerance: the receiver accepts a baud mismatch of ±2% between transmitter and receiver.

## Configuration
- `UART_PARITY_EN`: when defined, frames carry an even-parity bit after data bit 7 (11 bits per frame).
  - TX sends the parity bit for `CYCLE` clocks; `tx_data_ready` returns 1 at cycle `11*CYCLE+1`.
  - RX checks parity; a mismatch discards the byte, handled like a framing error.
- When undefined: plain 8N1 as described above, with no parity logic present.

## Test plan
- Loopback at defaults: offer 0xA5 for one cycle at t=100 ns.
  - Required: `tx_pin` bit sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), 868 clocks per bit.
  - Required: `rx_data`=0xA5 with valid high.
  - Required: `tx_data_ready` high again 8681 clocks after acceptance.
- Hold test: with `rx_data_ready`=0, send 0x3C after 0xA5 is consumed.
  - Required: `rx_data`=0x3C and `rx_data_valid` stays 1 until ready is raised; valid clears the cycle after ready=1.
- Overrun: keep `rx_data_ready`=0 and send 0x11 then 0x22.
  - Required: `rx_data`=0x22 and valid=1.
- Glitch and framing: drive a 100-clock low pulse on `rx_pin`.
  - Required: no valid. Restate the rule this checks: the start-bit recheck at `CYCLE/2` rejects it.
  - Drive a frame with the stop bit forced to 0.
  - Required: no valid, and the next correct frame is received.
- Reset mid-frame: assert `rst_n`=1 during TX bit 3.
  - Required: next clock `tx_pin`=1 and `tx_data_ready`=1.
  - Required: a subsequent 0x5A is transmitted and received intact.
- Parity (with `UART_PARITY_EN`): send 0x07.
  - Required: parity bit=1 on the line and the byte is received.
  - Flip the parity bit on the line. Required: no valid.
